uart_frame_receiver: RTL and testbench
======================================

# uart_frame_receiver

Parametrised successor to the fixed 8-bit operand UART receiver. It deserialises asynchronous serial frames from `rx`, clocked by the 16x oversample clock. Data width, oversample ratio and frame count are configurable. Adds a two-flop input synchroniser, 3-sample majority voting, frame-error reporting and optional parity checking. It sits between the board RX pin and the operand loader, and raises `done` once `FRAME_COUNT` good frames have arrived.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first; legal 5–9.
- `OVERSAMPLE`, 16: `clk` cycles per bit; even, minimum 8.
- `FRAME_COUNT`, 48: good frames before `done`; minimum 1.
- `PARITY_ODD`, 0: parity sense when parity is compiled in; 0 = even, 1 = odd.
- `CNT_W`, localparam $clog2(FRAME_COUNT+1): width of `frame_count`.
- `clk`  in  1  oversample clock, OVERSAMPLE x baud.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  receiver enable; low = synchronous clear.
- `rx`  in  1  raw serial line; idles high.
- `data`  out  DATA_BITS  last good frame; holds until the next good frame.
- `valid`  out  1  one-cycle pulse when `data` updates.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.
- `frame_count`  out  CNT_W  good frames received since clear.
- `done`  out  1  sticky; high once `frame_count == FRAME_COUNT`.

## Operation
- Reset values: all outputs 0. Synchroniser and vote registers reset to 1 (line idle). State resets to IDLE.
- `en` low: on the next edge, state goes to IDLE. All counters, `data`, `done`, `frame_count` and the pulse outputs go to 0. `en` takes precedence over every other event.
- `rx` passes through 2 flops to give `rx_s`. A 3-deep shift register of `rx_s` feeds the majority vote `maj`.
- States:
  - IDLE -> START on the first cycle with `rx_s == 0`. The tick counter is cleared.
  - START: the counter runs to `OVERSAMPLE/2-1`, the mid-bit point. `maj == 1` there is a false start -> IDLE, with no error pulse. Otherwise -> DATA.
  - DATA: sample `maj` every `OVERSAMPLE` ticks into bit index 0..DATA_BITS-1. After the last bit -> PARITY if compiled in, else STOP.
  - PARITY: one sample. Compare it with the XOR of the data bits, XORed with `PARITY_ODD`. -> STOP.
  - STOP: one sample.
    - Sampled high with no parity mismatch: load `data`, pulse `valid`, increment `frame_count`, -> IDLE, or -> DONE if the new count equals `FRAME_COUNT`.
    - Sampled high with a parity mismatch: pulse `parity_err`; `data` and count are unchanged; -> IDLE.
    - Sampled low: pulse `frame_err`; `data` and count are unchanged; -> BREAK.
  - BREAK: wait for `rx_s == 1`, then -> IDLE. This covers a line break or a misaligned start.
  - DONE: `done` = 1. Ignore `rx`. Leave only via `en` low or `rst`.
- The return to IDLE at the stop-bit midpoint lets a new start bit be accepted in the second half of the stop bit. This gives baud-mismatch tolerance.
- `frame_count` never wraps; it saturates at `FRAME_COUNT` because the block enters DONE.

## Timing
- `t0` is the first cycle `rx_s == 0`, which is 2 cycles after the `rx` pin falls.
- Start sample at `t0 + OVERSAMPLE/2 - 1`.
- Data bit i sampled at `t0 + OVERSAMPLE/2 - 1 + (i+1)*OVERSAMPLE`.
- Parity, then stop, are sampled at the following `OVERSAMPLE` steps.
- `valid`, `frame_err`, `parity_err`, the `data` update and the `frame_count` increment all appear on the registered cycle after the stop sample edge.
- `done` rises in the same cycle as the final `valid`.
- `maj` at a sample point votes over `rx_s` at that cycle and the 2 before it.
- `rst` asserted mid-frame clears immediately and asynchronously. The first frame after release is received normally.

## Configuration
- `UART_RX_PARITY_EN` defined: each frame carries one parity bit after the data. The PARITY state, the checker and `parity_err` are built.
- `UART_RX_PARITY_EN` undefined: there is no parity bit and STOP follows DATA directly. `parity_err` is tied to 0. `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_rx_pkg`:
  - state enum: IDLE, START, DATA, PARITY, STOP, BREAK, DONE.
  - idle-line constant `RX_IDLE = 1'b1`.
- Sub-module `uart_rx_sync_vote`: the 2-flop synchroniser plus 3-sample shift register. Outputs `rx_s` and `maj`.

## Test plan
All scenarios use the defaults: DATA_BITS=8, OVERSAMPLE=16, FRAME_COUNT=48.
- Send 0xA5 with a good stop bit -> `data`=0xA5, one `valid` pulse, `frame_count`=1, no error pulses.
- Drive `rx` low for 4 cycles in IDLE -> false start; no `valid`, no `frame_err`, back to IDLE. A following 0x3C is received correctly.
- Send 0x5A with the stop bit held low, then `rx` high -> one `frame_err` pulse. `data` and `frame_count` are unchanged, and a following 0x11 is received.
- Inject a 1-cycle inverted glitch at the mid-sample of data bit 3 of 0x00 -> the majority vote gives `data`=0x00 with `valid`.
- Send 49 frames 0x00..0x30 -> `done` rises with the 48th `valid`, `frame_count`=48, and the 49th frame produces no pulses. Then `en` low for one cycle -> all outputs 0.
- With `UART_RX_PARITY_EN`, `PARITY_ODD`=0: send 0x01 with parity bit 0 -> `parity_err` pulse, no `valid`. Send 0x01 with parity bit 1 -> `valid`, `data`=0x01.
- Assert `rst` during data bit 4 -> outputs 0 immediately. Send 0xFF after release -> received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART frame receiver.
// The state enum, the idle line level and the 3-sample majority helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK,
    DONE
  } rx_state_t;

  localparam logic RX_IDLE = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser for the raw rx pin plus a 3-sample history for majority voting.
// rx_s lags the pin by 2 cycles; maj votes over rx_s now and the 2 cycles before.
module uart_rx_sync_vote
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_maj
);

  logic [1:0] r_sync;
  logic [1:0] r_hist;

  // Everything powers up at the idle level so no phantom start bit appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {2{RX_IDLE}};
      r_hist <= {2{RX_IDLE}};
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_hist <= {r_hist[0], r_sync[1]};
    end
  end

  assign o_rx_s = r_sync[1];
  assign o_maj  = maj3(r_sync[1], r_hist[0], r_hist[1]);

endmodule

// File: rtl/uart_frame_receiver.sv
// Oversampled UART frame receiver: counts good frames and raises a sticky done at FRAME_COUNT.
// Define UART_RX_PARITY_EN to build the parity bit, PARITY state and parity_err checker.
module uart_frame_receiver
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FRAME_COUNT = 48,
  parameter bit          PARITY_ODD  = 1'b0,
  localparam int unsigned CNT_W      = $clog2(FRAME_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic [CNT_W-1:0]     frame_count,
  output logic                 done
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  rx_state_t            r_state, w_state_nxt;
  logic [TICK_W-1:0]    r_tick, w_tick_nxt;
  logic [BIT_W-1:0]     r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_data, w_data_nxt;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic                 r_par_bad, w_par_bad_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_ferr, w_ferr_nxt;
  logic                 r_perr, w_perr_nxt;
  logic                 w_rx_s, w_maj;
  logic                 w_mid, w_bit_end;
  logic [CNT_W-1:0]     w_count_inc;

  uart_rx_sync_vote u_sync_vote (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (rx),
    .o_rx_s (w_rx_s),
    .o_maj  (w_maj)
  );

  // The tick counter holds the number of cycles since the current sample window opened.
  assign w_mid       = (r_tick == TICK_W'(OVERSAMPLE / 2 - 1));
  assign w_bit_end   = (r_tick == TICK_W'(OVERSAMPLE - 1));
  assign w_count_inc = r_count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tick    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_count   <= '0;
      r_par_bad <= 1'b0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_count   <= w_count_nxt;
      r_par_bad <= w_par_bad_nxt;
      r_valid   <= w_valid_nxt;
      r_ferr    <= w_ferr_nxt;
      r_perr    <= w_perr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick + TICK_W'(1);
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_count_nxt   = r_count;
    w_par_bad_nxt = r_par_bad;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;
    w_perr_nxt    = 1'b0;
    if (!en) begin
      w_state_nxt   = IDLE;
      w_tick_nxt    = '0;
      w_bit_nxt     = '0;
      w_shift_nxt   = '0;
      w_data_nxt    = '0;
      w_count_nxt   = '0;
      w_par_bad_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_tick_nxt = '0;
          if (w_rx_s != RX_IDLE) begin
            w_state_nxt = START;
            w_tick_nxt  = TICK_W'(1);
          end
        end
        START: begin
          if (w_mid) begin
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = (w_maj == RX_IDLE) ? IDLE : DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {w_maj, r_shift[DATA_BITS-1:1]};
            w_bit_nxt   = r_bit + BIT_W'(1);
            if (r_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_state_nxt = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            w_tick_nxt    = '0;
            w_par_bad_nxt = w_maj ^ (^r_shift) ^ PARITY_ODD;
            w_state_nxt   = STOP;
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            w_tick_nxt    = '0;
            w_par_bad_nxt = 1'b0;
            if (w_maj != RX_IDLE) begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = BREAK;
            end else if (r_par_bad) begin
              w_perr_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
              w_count_nxt = w_count_inc;
              w_state_nxt = (w_count_inc == CNT_W'(FRAME_COUNT)) ? DONE : IDLE;
            end
          end
        end
        BREAK: begin
          w_tick_nxt = '0;
          if (w_rx_s == RX_IDLE) w_state_nxt = IDLE;
        end
        DONE: begin
          w_tick_nxt = '0;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign data        = r_data;
  assign valid       = r_valid;
  assign frame_err   = r_ferr;
  assign frame_count = r_count;
  assign done        = (r_state == DONE);

`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  logic w_unused;
  assign w_unused   = ^{PARITY_ODD, r_perr};
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Randomised frame stimulus for uart_frame_receiver, scored against a frame-level model.
module tb_uart_frame_receiver;

  localparam int DB   = 8;
  localparam int OS   = 16;
  localparam int FC   = 48;
  localparam int CW   = $clog2(FC + 1);
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          rx  = 1'b1;
  logic [DB-1:0] data;
  logic          valid, frame_err, parity_err, done;
  logic [CW-1:0] frame_count;

  always #5 clk = ~clk;

  uart_frame_receiver #(
    .DATA_BITS   (DB),
    .OVERSAMPLE  (OS),
    .FRAME_COUNT (FC),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .frame_count (frame_count),
    .done        (done)
  );

  int checks = 0;
  int failures = 0;

  // Pulse monitor, sampled on the falling edge.
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, last_valid_cyc = 0;
  bit done_seen = 0, done_rise_with_valid = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (frame_err === 1'b1) n_ferr++;
    if (parity_err === 1'b1) n_perr++;
    if (done === 1'b1 && !done_seen) begin
      done_seen = 1;
      done_rise_with_valid = (valid === 1'b1);
    end
    if (done !== 1'b1) done_seen = 0;
  end

  // Frame-level reference model.
  logic [DB-1:0] m_data = '0;
  int  m_count = 0;
  bit  m_done = 0;
  int  e_valid = 0, e_ferr = 0, e_perr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "/valid_cnt"}, n_valid, e_valid);
    check_eq({tag, "/ferr_cnt"}, n_ferr, e_ferr);
    check_eq({tag, "/perr_cnt"}, n_perr, e_perr);
    check_eq({tag, "/data"}, data, m_data);
    check_eq({tag, "/count"}, frame_count, m_count);
    check_eq({tag, "/done"}, done, m_done);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "/data"}, data, 0);
    check_eq({tag, "/valid"}, valid, 0);
    check_eq({tag, "/ferr"}, frame_err, 0);
    check_eq({tag, "/perr"}, parity_err, 0);
    check_eq({tag, "/count"}, frame_count, 0);
    check_eq({tag, "/done"}, done, 0);
  endtask

  task automatic model_clear();
    m_data  = '0;
    m_count = 0;
    m_done  = 0;
  endtask

  task automatic model_frame(input logic [DB-1:0] d, input bit stop_ok, input bit bad_par);
    if (m_done) return;
    if (!stop_ok) e_ferr++;
    else if (bad_par) e_perr++;
    else begin
      e_valid++;
      m_data = d;
      m_count++;
      if (m_count == FC) m_done = 1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame pin-cycle by pin-cycle; glitch_at inverts one cycle, cut_after truncates.
  task automatic send_frame(input logic [DB-1:0] d, input bit stop_ok, input bit bad_par,
                            input int glitch_at, input int cut_after, output int base);
    logic bits[$];
    logic v;
    int   total;
    base = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (PAR_EN) bits.push_back((^d) ^ PODD ^ bad_par);
    bits.push_back(stop_ok);
    total = bits.size() * OS;
    for (int c = 1; c <= total; c++) begin
      if (cut_after > 0 && c > cut_after) break;
      @(negedge clk);
      if (c == 1) base = cyc;
      v = bits[(c - 1) / OS];
      if (c == glitch_at) v = ~v;
      rx = v;
    end
  endtask

  task automatic do_frame(input logic [DB-1:0] d, input bit stop_ok, input bit bad_par,
                          input int glitch_at, input int gap, output int base);
    send_frame(d, stop_ok, bad_par, glitch_at, 0, base);
    if (!stop_ok) begin
      rx = 1'b0;
      repeat (8) @(negedge clk);
    end
    idle(gap);
    model_frame(d, stop_ok, bad_par);
  endtask

  task automatic false_start();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(30);
  endtask

  int base;
  int kind;
  logic [DB-1:0] rd;

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    en  = 1'b1;
    idle(5);

    do_frame(8'hA5, 1, 0, 0, 4, base);
    check_all("a5");
    check_eq("a5/latency", last_valid_cyc - base, 154 + (PAR_EN ? OS : 0));

    false_start();
    check_all("false_start");
    do_frame(8'h3C, 1, 0, 0, 4, base);
    check_all("3c");

    do_frame(8'h5A, 0, 0, 0, 6, base);
    check_all("stop_low");
    do_frame(8'h11, 1, 0, 0, 4, base);
    check_all("11");

    // Bit 3 covers pin cycles 65..80; cycle 72 is the lone sample a non-voting receiver would take.
    do_frame(8'h00, 1, 0, 72, 4, base);
    check_all("glitch");

`ifdef UART_RX_PARITY_EN
    do_frame(8'h01, 1, 1, 0, 4, base);
    check_all("par_bad");
    do_frame(8'h01, 1, 0, 0, 4, base);
    check_all("par_good");
`endif

    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 9);
      rd   = DB'($urandom);
      if (kind < 2) false_start();
      else if (kind < 4) do_frame(rd, 0, 0, 0, $urandom_range(2, 20), base);
      else if (kind == 4 && PAR_EN) do_frame(rd, 1, 1, 0, $urandom_range(2, 20), base);
      else do_frame(rd, 1, 0, 0, $urandom_range(2, 20), base);
      check_all("rand");
    end

    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    model_clear();
    check_zero("en_clear");
    en = 1'b1;
    idle(3);

    for (int i = 0; i <= FC; i++) begin
      do_frame(DB'(i), 1, 0, 0, 2, base);
      check_all("fill");
    end
    check_eq("done_with_valid", done_rise_with_valid, 1);

    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    model_clear();
    check_zero("done_clear");
    en = 1'b1;
    idle(3);

    do_frame(8'h66, 1, 0, 0, 4, base);
    check_all("pre_rst");
    send_frame(8'hC3, 1, 0, 0, 88, base);
    #2;
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    model_clear();
    check_zero("async_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);
    do_frame(8'hFF, 1, 0, 0, 4, base);
    check_all("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
